rp_cpl_tag_tracker: RTL and testbench

//  Root-port BFM tag manager between the packet receiver's completion stream and the tester MMIO response logic.
//  - Hands out free tags for outbound non-posted MMIO reads and records the expected requester/completer IDs.
//  - Matches returning CplD TLPs to their tag, checks the IDs and forwards one response per tag.
//  - Retires tags that never complete after a fixed timeout, reporting them as timeout errors.

---
 rtl/rp_cpl_tag_tracker.sv | 224 ++++++++++++++++++++++
 tb/tb_rp_cpl_tag_tracker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rp_cpl_tag_tracker.sv
// Root-port tag tracker: allocates read tags, matches returning completions by tag,
// and retires tags that never complete as timeout responses through a one-entry output register.
module rp_cpl_tag_tracker #(
   parameter int MAX_TAGS    = 64,
   parameter int TAG_W       = $clog2(MAX_TAGS),
   parameter int DATA_W      = 64,
   parameter int TIMEOUT_CYC = 4096,
   parameter int TMO_W       = $clog2(TIMEOUT_CYC + 1)
) (
   input  logic              avl_clk,
   input  logic              avl_rst,
   input  logic              i_alloc_req,
   input  logic [15:0]       i_alloc_rid,
   input  logic [15:0]       i_alloc_cid,
   output logic              o_alloc_gnt,
   output logic [TAG_W-1:0]  o_alloc_tag,
   output logic [TAG_W:0]    o_free_cnt,
   input  logic              i_cpl_valid,
   output logic              o_cpl_ready,
   input  logic [TAG_W-1:0]  i_cpl_tag,
   input  logic [15:0]       i_cpl_rid,
   input  logic [15:0]       i_cpl_cid,
   input  logic [2:0]        i_cpl_status,
   input  logic [DATA_W-1:0] i_cpl_data,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [TAG_W-1:0]  o_rsp_tag,
   output logic [DATA_W-1:0] o_rsp_data,
   output logic [2:0]        o_rsp_status,
   output logic [1:0]        o_rsp_err,
   output logic              o_unexp_cpl,
   output logic [TAG_W-1:0]  o_unexp_tag
);

   logic [MAX_TAGS-1:0] active_q, active_d;
   logic [MAX_TAGS-1:0] pend_q, pend_d;
   logic [TMO_W-1:0]    cnt_q [MAX_TAGS];
   logic [TMO_W-1:0]    cnt_d [MAX_TAGS];
   logic [15:0]         rid_q [MAX_TAGS];
   logic [15:0]         rid_d [MAX_TAGS];
   logic [15:0]         cid_q [MAX_TAGS];
   logic [15:0]         cid_d [MAX_TAGS];

   logic              rsp_valid_q, rsp_valid_d;
   logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [2:0]        rsp_status_q, rsp_status_d;
   logic [1:0]        rsp_err_q, rsp_err_d;
   logic              alloc_gnt_q, alloc_gnt_d;
   logic [TAG_W-1:0]  alloc_tag_q, alloc_tag_d;
   logic [TAG_W:0]    free_cnt_q, free_cnt_d;
   logic              unexp_q, unexp_d;
   logic [TAG_W-1:0]  unexp_tag_q, unexp_tag_d;
   // Tag freed at the previous edge; held back from allocation for one more cycle.
   logic              rcl_vld_q, rcl_vld_d;
   logic [TAG_W-1:0]  rcl_tag_q, rcl_tag_d;

   logic             cpl_ready;
   logic             cpl_acc;
   logic             cpl_hit;
   logic             gnt_ok;
   logic [TAG_W-1:0] gnt_idx;
   logic             pend_any;
   logic [TAG_W-1:0] pend_idx;
   logic             gnt;
   logic             free_hit;
   logic [TAG_W-1:0] free_idx;

   assign cpl_ready = ~rsp_valid_q | i_rsp_ready;
   assign cpl_acc   = i_cpl_valid & cpl_ready;
   assign cpl_hit   = cpl_acc & active_q[i_cpl_tag];
   assign gnt       = i_alloc_req & gnt_ok;

   always_comb begin
      gnt_ok  = 1'b0;
      gnt_idx = '0;
      for (int i = MAX_TAGS - 1; i >= 0; i--) begin
         if (!active_q[i] && !(rcl_vld_q && rcl_tag_q == TAG_W'(i))) begin
            gnt_ok  = 1'b1;
            gnt_idx = TAG_W'(i);
         end
      end
   end

   always_comb begin
      pend_any = 1'b0;
      pend_idx = '0;
      for (int i = MAX_TAGS - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            pend_any = 1'b1;
            pend_idx = TAG_W'(i);
         end
      end
   end

   always_comb begin
      active_d     = active_q;
      pend_d       = pend_q;
      cnt_d        = cnt_q;
      rid_d        = rid_q;
      cid_d        = cid_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_tag_d    = rsp_tag_q;
      rsp_data_d   = rsp_data_q;
      rsp_status_d = rsp_status_q;
      rsp_err_d    = rsp_err_q;
      alloc_gnt_d  = gnt;
      alloc_tag_d  = gnt ? gnt_idx : alloc_tag_q;
      unexp_d      = 1'b0;
      unexp_tag_d  = unexp_tag_q;
      free_hit     = 1'b0;
      free_idx     = '0;

      if (rsp_valid_q && i_rsp_ready) rsp_valid_d = 1'b0;

      for (int i = 0; i < MAX_TAGS; i++) begin
         if (active_q[i] && cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - TMO_W'(1);
            if (cnt_q[i] == TMO_W'(1)) pend_d[i] = 1'b1;
         end
      end

      if (cpl_hit) begin
         rsp_valid_d  = 1'b1;
         rsp_tag_d    = i_cpl_tag;
         rsp_data_d   = i_cpl_data;
         rsp_status_d = i_cpl_status;
         rsp_err_d    = {1'b0, (i_cpl_rid != rid_q[i_cpl_tag]) || (i_cpl_cid != cid_q[i_cpl_tag])};
         free_hit     = 1'b1;
         free_idx     = i_cpl_tag;
      end else begin
         if (cpl_acc) begin
            unexp_d     = 1'b1;
            unexp_tag_d = i_cpl_tag;
         end
         if (cpl_ready && pend_any) begin
            rsp_valid_d  = 1'b1;
            rsp_tag_d    = pend_idx;
            rsp_data_d   = '0;
            rsp_status_d = 3'b001;
            rsp_err_d    = 2'b10;
            free_hit     = 1'b1;
            free_idx     = pend_idx;
         end
      end

      // A freed tag also drops a timeout that would have been flagged this same cycle.
      if (free_hit) begin
         active_d[free_idx] = 1'b0;
         pend_d[free_idx]   = 1'b0;
         cnt_d[free_idx]    = '0;
      end

      if (gnt) begin
         active_d[gnt_idx] = 1'b1;
         pend_d[gnt_idx]   = 1'b0;
         cnt_d[gnt_idx]    = TMO_W'(TIMEOUT_CYC);
         rid_d[gnt_idx]    = i_alloc_rid;
         cid_d[gnt_idx]    = i_alloc_cid;
      end

      free_cnt_d = free_cnt_q;
      if (gnt && !free_hit)      free_cnt_d = free_cnt_q - (TAG_W+1)'(1);
      else if (free_hit && !gnt) free_cnt_d = free_cnt_q + (TAG_W+1)'(1);

      rcl_vld_d = free_hit;
      rcl_tag_d = free_idx;
   end

   always_ff @(posedge avl_clk or posedge avl_rst) begin
      if (avl_rst) begin
         active_q     <= '0;
         pend_q       <= '0;
         for (int i = 0; i < MAX_TAGS; i++) begin
            cnt_q[i] <= '0;
            rid_q[i] <= '0;
            cid_q[i] <= '0;
         end
         rsp_valid_q  <= 1'b0;
         rsp_tag_q    <= '0;
         rsp_data_q   <= '0;
         rsp_status_q <= '0;
         rsp_err_q    <= '0;
         alloc_gnt_q  <= 1'b0;
         alloc_tag_q  <= '0;
         free_cnt_q   <= (TAG_W+1)'(MAX_TAGS);
         unexp_q      <= 1'b0;
         unexp_tag_q  <= '0;
         rcl_vld_q    <= 1'b0;
         rcl_tag_q    <= '0;
      end else begin
         active_q     <= active_d;
         pend_q       <= pend_d;
         cnt_q        <= cnt_d;
         rid_q        <= rid_d;
         cid_q        <= cid_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_tag_q    <= rsp_tag_d;
         rsp_data_q   <= rsp_data_d;
         rsp_status_q <= rsp_status_d;
         rsp_err_q    <= rsp_err_d;
         alloc_gnt_q  <= alloc_gnt_d;
         alloc_tag_q  <= alloc_tag_d;
         free_cnt_q   <= free_cnt_d;
         unexp_q      <= unexp_d;
         unexp_tag_q  <= unexp_tag_d;
         rcl_vld_q    <= rcl_vld_d;
         rcl_tag_q    <= rcl_tag_d;
      end
   end

   assign o_cpl_ready  = cpl_ready;
   assign o_alloc_gnt  = alloc_gnt_q;
   assign o_alloc_tag  = alloc_tag_q;
   assign o_free_cnt   = free_cnt_q;
   assign o_rsp_valid  = rsp_valid_q;
   assign o_rsp_tag    = rsp_tag_q;
   assign o_rsp_data   = rsp_data_q;
   assign o_rsp_status = rsp_status_q;
   assign o_rsp_err    = rsp_err_q;
   assign o_unexp_cpl  = unexp_q;
   assign o_unexp_tag  = unexp_tag_q;

endmodule

// File: tb/tb_rp_cpl_tag_tracker.sv
// Directed bench for rp_cpl_tag_tracker: allocation, completion matching, ID check,
// timeout retirement, exhaustion/reuse spacing and response backpressure.
module tb_rp_cpl_tag_tracker;

   localparam int T = 4096;
   localparam logic [15:0] RID_A = 16'h0001;
   localparam logic [15:0] CID_A = 16'h0002;

   logic        clk = 1'b0;
   logic        rst;
   logic        alloc_req;
   logic [15:0] alloc_rid, alloc_cid;
   logic        alloc_gnt;
   logic [5:0]  alloc_tag;
   logic [6:0]  free_cnt;
   logic        cpl_valid, cpl_ready;
   logic [5:0]  cpl_tag;
   logic [15:0] cpl_rid, cpl_cid;
   logic [2:0]  cpl_status;
   logic [63:0] cpl_data;
   logic        rsp_valid, rsp_ready;
   logic [5:0]  rsp_tag;
   logic [63:0] rsp_data;
   logic [2:0]  rsp_status;
   logic [1:0]  rsp_err;
   logic        unexp_cpl;
   logic [5:0]  unexp_tag;

   int total = 0;
   int bad   = 0;

   rp_cpl_tag_tracker dut (
      .avl_clk(clk), .avl_rst(rst),
      .i_alloc_req(alloc_req), .i_alloc_rid(alloc_rid), .i_alloc_cid(alloc_cid),
      .o_alloc_gnt(alloc_gnt), .o_alloc_tag(alloc_tag), .o_free_cnt(free_cnt),
      .i_cpl_valid(cpl_valid), .o_cpl_ready(cpl_ready), .i_cpl_tag(cpl_tag),
      .i_cpl_rid(cpl_rid), .i_cpl_cid(cpl_cid), .i_cpl_status(cpl_status), .i_cpl_data(cpl_data),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_tag(rsp_tag),
      .o_rsp_data(rsp_data), .o_rsp_status(rsp_status), .o_rsp_err(rsp_err),
      .o_unexp_cpl(unexp_cpl), .o_unexp_tag(unexp_tag)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic grant_one(input logic [15:0] rid, input logic [15:0] cid,
                            output logic g, output logic [5:0] t);
      alloc_req = 1'b1;
      alloc_rid = rid;
      alloc_cid = cid;
      tick();
      g = alloc_gnt;
      t = alloc_tag;
      alloc_req = 1'b0;
   endtask

   task automatic send_cpl(input logic [5:0] tag, input logic [15:0] rid, input logic [15:0] cid,
                           input logic [2:0] st, input logic [63:0] d);
      cpl_valid  = 1'b1;
      cpl_tag    = tag;
      cpl_rid    = rid;
      cpl_cid    = cid;
      cpl_status = st;
      cpl_data   = d;
      tick();
      cpl_valid  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      alloc_req = 0; alloc_rid = 0; alloc_cid = 0;
      cpl_valid = 0; cpl_tag = 0; cpl_rid = 0; cpl_cid = 0; cpl_status = 0; cpl_data = 0;
      rsp_ready = 1'b1;
      tick(); tick();
      total++; if (free_cnt !== 7'd64) begin bad++; $display("FAIL reset_free_cnt got=%0d want=64", free_cnt); end
      total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%0b want=0", alloc_gnt); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0b want=0", rsp_valid); end
      total++; if (unexp_cpl !== 1'b0) begin bad++; $display("FAIL reset_unexp got=%0b want=0", unexp_cpl); end
      total++; if ({rsp_tag, rsp_data, rsp_status, rsp_err} !== '0) begin bad++; $display("FAIL reset_rsp_payload got=%0h want=0", {rsp_tag, rsp_data, rsp_status, rsp_err}); end
      total++; if (cpl_ready !== 1'b1) begin bad++; $display("FAIL reset_cpl_ready got=%0b want=1", cpl_ready); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_alloc_seq();
      alloc_req = 1'b1; alloc_rid = RID_A; alloc_cid = CID_A;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (alloc_gnt !== 1'b1 || alloc_tag !== 6'(i)) begin bad++; $display("FAIL alloc_seq_gnt%0d got=%0b/%0d want=1/%0d", i, alloc_gnt, alloc_tag, i); end
         total++; if (free_cnt !== 7'(63 - i)) begin bad++; $display("FAIL alloc_seq_cnt%0d got=%0d want=%0d", i, free_cnt, 63 - i); end
      end
      alloc_req = 1'b0;
      tick();
      total++; if (alloc_gnt !== 1'b0 || free_cnt !== 7'd61) begin bad++; $display("FAIL alloc_seq_idle got=%0b/%0d want=0/61", alloc_gnt, free_cnt); end
   endtask

   task automatic test_cpl_ok();
      logic g; logic [5:0] t;
      grant_one(RID_A, CID_A, g, t);
      total++; if (g !== 1'b1 || t !== 6'd3) begin bad++; $display("FAIL cpl_ok_gnt3 got=%0b/%0d want=1/3", g, t); end
      grant_one(RID_A, CID_A, g, t);
      total++; if (g !== 1'b1 || t !== 6'd4) begin bad++; $display("FAIL cpl_ok_gnt4 got=%0b/%0d want=1/4", g, t); end
      grant_one(16'h0100, 16'h0009, g, t);
      total++; if (g !== 1'b1 || t !== 6'd5 || free_cnt !== 7'd58) begin bad++; $display("FAIL cpl_ok_gnt5 got=%0b/%0d/%0d want=1/5/58", g, t, free_cnt); end
      send_cpl(6'd5, 16'h0100, 16'h0009, 3'b000, 64'hDEADBEEF_12345678);
      total++; if (rsp_valid !== 1'b1 || rsp_tag !== 6'd5 || rsp_err !== 2'b00 || rsp_status !== 3'b000) begin bad++; $display("FAIL cpl_ok_rsp got=%0b/%0d/%0b/%0b want=1/5/00/000", rsp_valid, rsp_tag, rsp_err, rsp_status); end
      total++; if (rsp_data !== 64'hDEADBEEF_12345678) begin bad++; $display("FAIL cpl_ok_data got=%0h want=deadbeef12345678", rsp_data); end
      total++; if (free_cnt !== 7'd59) begin bad++; $display("FAIL cpl_ok_cnt got=%0d want=59", free_cnt); end
      tick();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL cpl_ok_consumed got=%0b want=0", rsp_valid); end
   endtask

   task automatic test_id_mismatch();
      logic g; logic [5:0] t;
      grant_one(16'h0100, 16'h0009, g, t);
      total++; if (g !== 1'b1 || t !== 6'd5) begin bad++; $display("FAIL idm_gnt got=%0b/%0d want=1/5", g, t); end
      send_cpl(6'd5, 16'h0100, 16'h0001, 3'b010, 64'h0123_4567_89AB_CDEF);
      total++; if (rsp_valid !== 1'b1 || rsp_tag !== 6'd5 || rsp_err !== 2'b01 || rsp_status !== 3'b010) begin bad++; $display("FAIL idm_rsp got=%0b/%0d/%0b/%0b want=1/5/01/010", rsp_valid, rsp_tag, rsp_err, rsp_status); end
      total++; if (rsp_data !== 64'h0123_4567_89AB_CDEF || free_cnt !== 7'd59) begin bad++; $display("FAIL idm_data_cnt got=%0h/%0d want=123456789abcdef/59", rsp_data, free_cnt); end
      send_cpl(6'd5, 16'h0100, 16'h0009, 3'b000, 64'h1);
      total++; if (unexp_cpl !== 1'b1 || unexp_tag !== 6'd5) begin bad++; $display("FAIL idm_unexp got=%0b/%0d want=1/5", unexp_cpl, unexp_tag); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL idm_no_rsp got=%0b want=0", rsp_valid); end
      tick();
      total++; if (unexp_cpl !== 1'b0) begin bad++; $display("FAIL idm_unexp_pulse got=%0b want=0", unexp_cpl); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) begin
         send_cpl(6'(i), RID_A, CID_A, 3'b000, 64'h1000 + 64'(i));
         total++; if (rsp_valid !== 1'b1 || rsp_tag !== 6'(i) || rsp_err !== 2'b00 || rsp_data !== 64'h1000 + 64'(i)) begin bad++; $display("FAIL b2b_rsp%0d got=%0b/%0d/%0b/%0h", i, rsp_valid, rsp_tag, rsp_err, rsp_data); end
      end
      total++; if (free_cnt !== 7'd64) begin bad++; $display("FAIL b2b_cnt got=%0d want=64", free_cnt); end
      tick();
   endtask

   task automatic test_timeout();
      logic g; logic [5:0] t; int n;
      tick();
      grant_one(RID_A, CID_A, g, t);
      total++; if (g !== 1'b1 || t !== 6'd0) begin bad++; $display("FAIL tmo_gnt got=%0b/%0d want=1/0", g, t); end
      n = 0;
      while (rsp_valid !== 1'b1 && n < T + 20) begin
         tick();
         n++;
      end
      total++; if (n !== T + 1) begin bad++; $display("FAIL tmo_latency got=%0d want=%0d", n, T + 1); end
      total++; if (rsp_tag !== 6'd0 || rsp_data !== 64'd0 || rsp_status !== 3'b001 || rsp_err !== 2'b10) begin bad++; $display("FAIL tmo_rsp got=%0d/%0h/%0b/%0b want=0/0/001/10", rsp_tag, rsp_data, rsp_status, rsp_err); end
      total++; if (free_cnt !== 7'd64) begin bad++; $display("FAIL tmo_cnt got=%0d want=64", free_cnt); end
      send_cpl(6'd0, RID_A, CID_A, 3'b000, 64'h55);
      total++; if (unexp_cpl !== 1'b1 || unexp_tag !== 6'd0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL tmo_late_cpl got=%0b/%0d/%0b want=1/0/0", unexp_cpl, unexp_tag, rsp_valid); end
      tick();
   endtask

   task automatic test_full();
      alloc_req = 1'b1; alloc_rid = RID_A; alloc_cid = CID_A;
      for (int i = 0; i < 64; i++) begin
         tick();
         total++; if (alloc_gnt !== 1'b1 || alloc_tag !== 6'(i)) begin bad++; $display("FAIL full_gnt%0d got=%0b/%0d", i, alloc_gnt, alloc_tag); end
      end
      total++; if (free_cnt !== 7'd0) begin bad++; $display("FAIL full_cnt got=%0d want=0", free_cnt); end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL full_nognt%0d got=%0b want=0", i, alloc_gnt); end
      end
      send_cpl(6'd17, RID_A, CID_A, 3'b000, 64'h17);
      total++; if (rsp_valid !== 1'b1 || rsp_tag !== 6'd17 || free_cnt !== 7'd1 || alloc_gnt !== 1'b0) begin bad++; $display("FAIL full_free17 got=%0b/%0d/%0d/%0b want=1/17/1/0", rsp_valid, rsp_tag, free_cnt, alloc_gnt); end
      tick();
      total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL full_reuse_early got=%0b want=0", alloc_gnt); end
      tick();
      total++; if (alloc_gnt !== 1'b1 || alloc_tag !== 6'd17 || free_cnt !== 7'd0) begin bad++; $display("FAIL full_reuse got=%0b/%0d/%0d want=1/17/0", alloc_gnt, alloc_tag, free_cnt); end
      alloc_req = 1'b0;
      for (int i = 0; i < 64; i++) begin
         send_cpl(6'(i), RID_A, CID_A, 3'b000, 64'(i));
         total++; if (rsp_valid !== 1'b1 || rsp_tag !== 6'(i) || rsp_err !== 2'b00) begin bad++; $display("FAIL drain_rsp%0d got=%0b/%0d/%0b", i, rsp_valid, rsp_tag, rsp_err); end
      end
      total++; if (free_cnt !== 7'd64) begin bad++; $display("FAIL drain_cnt got=%0d want=64", free_cnt); end
      tick();
   endtask

   task automatic test_backpressure();
      alloc_req = 1'b1; alloc_rid = RID_A; alloc_cid = CID_A;
      tick(); tick(); tick();
      total++; if (alloc_gnt !== 1'b1 || alloc_tag !== 6'd2) begin bad++; $display("FAIL bp_gnt got=%0b/%0d want=1/2", alloc_gnt, alloc_tag); end
      alloc_req = 1'b0;
      repeat (T - 8) tick();
      rsp_ready = 1'b0;
      send_cpl(6'd1, RID_A, CID_A, 3'b000, 64'hAAAA);
      cpl_valid = 1'b1; cpl_tag = 6'd2; cpl_rid = RID_A; cpl_cid = CID_A;
      cpl_status = 3'b100; cpl_data = 64'hBBBB;
      #1;
      for (int i = 0; i < 10; i++) begin
         total++; if (cpl_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_tag !== 6'd1 || rsp_data !== 64'hAAAA) begin bad++; $display("FAIL bp_hold%0d got=%0b/%0b/%0d/%0h want=0/1/1/aaaa", i, cpl_ready, rsp_valid, rsp_tag, rsp_data); end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      cpl_valid = 1'b0;
      total++; if (rsp_valid !== 1'b1 || rsp_tag !== 6'd2 || rsp_err !== 2'b00 || rsp_status !== 3'b100 || rsp_data !== 64'hBBBB) begin bad++; $display("FAIL bp_cpl_first got=%0b/%0d/%0b/%0b/%0h want=1/2/00/100/bbbb", rsp_valid, rsp_tag, rsp_err, rsp_status, rsp_data); end
      tick();
      total++; if (rsp_valid !== 1'b1 || rsp_tag !== 6'd0 || rsp_err !== 2'b10 || rsp_status !== 3'b001 || rsp_data !== 64'd0) begin bad++; $display("FAIL bp_tmo_second got=%0b/%0d/%0b/%0b/%0h want=1/0/10/001/0", rsp_valid, rsp_tag, rsp_err, rsp_status, rsp_data); end
      tick();
      total++; if (rsp_valid !== 1'b0 || free_cnt !== 7'd64) begin bad++; $display("FAIL bp_end got=%0b/%0d want=0/64", rsp_valid, free_cnt); end
   endtask

   task automatic test_reset_mid();
      logic g; logic [5:0] t;
      grant_one(RID_A, CID_A, g, t);
      grant_one(RID_A, CID_A, g, t);
      rsp_ready = 1'b0;
      send_cpl(6'd0, RID_A, CID_A, 3'b000, 64'h77);
      total++; if (rsp_valid !== 1'b1 || free_cnt !== 7'd63) begin bad++; $display("FAIL rmid_pre got=%0b/%0d want=1/63", rsp_valid, free_cnt); end
      #2 rst = 1'b1;
      #1;
      total++; if (rsp_valid !== 1'b0 || free_cnt !== 7'd64) begin bad++; $display("FAIL rmid_async got=%0b/%0d want=0/64", rsp_valid, free_cnt); end
      rst = 1'b0;
      rsp_ready = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_alloc_seq();
      test_cpl_ok();
      test_id_mismatch();
      test_back_to_back();
      test_timeout();
      test_full();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
